iter_alu: RTL
=============

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width taken from src_b[SHW-1:0].
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-005 flush  input  1  abandon in-flight operation, return to IDLE.
REQ-006 in_valid  input  1  operation request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 op  input  5  operation code (alu_pkg::alu_op_e).
REQ-009 src_a  input  XLEN  operand A.
REQ-010 src_b  input  XLEN  operand B.
REQ-011 out_valid  output  1  result registers hold a valid result.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  XLEN  operation result.
REQ-014 zero  output  1  registered (src_a == src_b) of the accepted request.
REQ-015 signed_less  output  1  registered signed src_a < src_b.
REQ-016 unsigned_less  output  1  registered unsigned src_a < src_b.

Function
REQ-017 Ops 0..10 SHALL be ADD, SUB, AND, OR, XOR, SLTU, SLT, PASSB, SLL, SRL, SRA; 11..18 MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; 19..31 SHALL yield result 0 with latency 1.
REQ-018 Arithmetic SHALL wrap modulo 2^XLEN; SLT/SLTU result 1 or 0, zero-extended.
REQ-019 All shifts SHALL use only src_b[SHW-1:0]; SRA SHALL replicate src_a[XLEN-1].
REQ-020 FSM states IDLE, CALC, DONE; in_ready SHALL equal (state==IDLE).
REQ-021 Handshake fires when in_valid && in_ready; operands, op and flags SHALL be captured that cycle.
REQ-022 IDLE->DONE next cycle for ops 0..10, 19..31, and divide special cases (latency 1).
REQ-023 IDLE->CALC for MUL*/DIV*/REM* otherwise; CALC SHALL last exactly XLEN cycles (one bit per cycle, shift-add multiply, restoring divide on magnitudes), then ->DONE.
REQ-024 MULH/MULHSU/MULHU SHALL return upper XLEN bits of signed*signed, signed*unsigned, unsigned*unsigned 2XLEN products; MUL lower XLEN bits.
REQ-025 Divide by zero: DIV/DIVU quotient all-ones, REM/REMU remainder = src_a.
REQ-026 Signed overflow (DIV of most-negative by -1): quotient most-negative, REM remainder 0.
REQ-027 Signed quotient SHALL truncate toward zero; remainder sign SHALL follow dividend.
REQ-028 out_valid SHALL equal (state==DONE); result/flags SHALL be stable while out_valid && !out_ready.
REQ-029 DONE->IDLE on out_ready; no new request is accepted in the same cycle (no bypass).
REQ-030 flush SHALL force IDLE next cycle from any state, deasserting out_valid; flush overrides in_valid and out_ready.
REQ-031 in_valid while in_ready low SHALL be ignored; requester must hold request.

Reset
REQ-032 rst_n low at a clock edge SHALL force IDLE, out_valid 0, result 0, zero/signed_less/unsigned_less 0, in_ready 1 from next cycle.
REQ-033 Reset mid-CALC or in DONE SHALL discard the operation; no partial result SHALL appear.
REQ-034 in_ready SHALL be 0 while rst_n is low.

Structure
REQ-035 Package alu_pkg SHALL hold alu_op_e enum (5-bit), state enum, XLEN default constant.
REQ-036 Sub-module iter_muldiv SHALL implement the XLEN-cycle multiply/divide datapath with start/done pins; iter_alu holds FSM, single-cycle ops, special-case detection.

Verification
REQ-037 XLEN=32, ADD 0xFFFFFFFF+1 -> result 0x00000000, zero 0, out_valid 1 cycle after handshake.
REQ-038 SRA src_a=0x80000000, src_b=0x00000024 -> shift 4, result 0xF8000000.
REQ-039 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE; out_valid at cycle 33.
REQ-040 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 latency 1; DIVU 7/0 -> 0xFFFFFFFF; REM -7/2 -> 0xFFFFFFFF.
REQ-041 out_ready held low 5 cycles after DIVU 100/7 -> result 14 stable, in_ready 0 throughout.
REQ-042 flush (or rst_n low) at CALC cycle 10 of MUL -> IDLE next cycle, out_valid never asserted, next ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the iterative ALU.
// is_muldiv marks the opcodes that go through the multi-cycle datapath.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLTU   = 5'd5,
    OP_SLT    = 5'd6,
    OP_PASSB  = 5'd7,
    OP_SLL    = 5'd8,
    OP_SRL    = 5'd9,
    OP_SRA    = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= 5'd11) && (op <= 5'd18);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// XLEN-cycle multiply/divide datapath working on operand magnitudes.
// Signs are restored on the way out; divide special cases are filtered by iter_alu.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  alu_op_e opc;
  logic a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  logic running;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] hi, lo, mcand, hi_nx, lo_nx;
  logic is_div_q, sel_hi_q, sel_rem_q, neg_main_q, neg_rem_q;

  logic [XLEN:0] sum, shifted, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;

  assign opc = alu_op_e'(op);

  always_comb begin
    a_signed = opc inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = opc inside {OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_signed & src_a[XLEN-1];
    b_neg    = b_signed & src_b[XLEN-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
  end

  // hi/lo double as {partial product, multiplier} or {remainder, dividend/quotient}
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running    <= 1'b1;
      cnt        <= '0;
      hi         <= '0;
      lo         <= a_mag;
      mcand      <= b_mag;
      is_div_q   <= opc inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      sel_hi_q   <= opc inside {OP_MULH, OP_MULHSU, OP_MULHU};
      sel_rem_q  <= opc inside {OP_REM, OP_REMU};
      neg_main_q <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
    end else if (running) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) running <= 1'b0;
    end
  end

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, mcand};
    if (is_div_q) begin
      if (!diff[XLEN]) begin
        hi_nx = diff[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = shifted[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], lo[XLEN-1:1]};
    end

    // Result is taken from the final step's next-state so it lands with done
    prod = {hi_nx, lo_nx};
    if (neg_main_q) prod = -prod;
    quo = neg_main_q ? -lo_nx : lo_nx;
    rem = neg_rem_q ? -hi_nx : hi_nx;

    if (is_div_q) result = sel_rem_q ? rem : quo;
    else          result = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  assign done = running && (cnt == LAST);

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle ops and divide special cases complete in one cycle,
// multiply/divide run through iter_muldiv; valid/ready handshake on both sides.
module iter_alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            signed_less,
  output logic            unsigned_less
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;
  alu_op_e opc;
  logic fire, is_md, is_divop, div_zero, div_ovf, special, multi;
  logic md_done;
  logic [XLEN-1:0] quick, md_result;
  logic [SHW-1:0] shamt;

  assign opc   = alu_op_e'(op);
  assign shamt = src_b[SHW-1:0];

  always_comb begin
    div_zero = (src_b == '0);
    div_ovf  = (src_a == MIN_NEG) && (src_b == '1);
    quick    = '0;
    case (opc)
      OP_ADD:   quick = src_a + src_b;
      OP_SUB:   quick = src_a - src_b;
      OP_AND:   quick = src_a & src_b;
      OP_OR:    quick = src_a | src_b;
      OP_XOR:   quick = src_a ^ src_b;
      OP_SLTU:  quick = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_SLT:   quick = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_PASSB: quick = src_b;
      OP_SLL:   quick = src_a << shamt;
      OP_SRL:   quick = src_a >> shamt;
      OP_SRA:   quick = $signed(src_a) >>> shamt;
      OP_DIV, OP_DIVU: quick = div_zero ? '1 : MIN_NEG;
      OP_REM, OP_REMU: quick = div_zero ? src_a : '0;
      default:  quick = '0;
    endcase
  end

  always_comb begin
    is_md    = is_muldiv(op);
    is_divop = opc inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    special  = is_divop && (div_zero || (div_ovf && (opc inside {OP_DIV, OP_REM})));
    multi    = is_md && !special;
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && rst_n;
    out_valid = (state_q == S_DONE);
    fire      = in_valid && in_ready && !flush;
    state_d   = state_q;
    case (state_q)
      S_IDLE: if (fire) state_d = multi ? S_CALC : S_DONE;
      S_CALC: if (md_done) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Flags are captured with the request; result arrives either now or from the datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      result        <= '0;
      zero          <= 1'b0;
      signed_less   <= 1'b0;
      unsigned_less <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        result        <= '0;
        zero          <= 1'b0;
        signed_less   <= 1'b0;
        unsigned_less <= 1'b0;
      end else if (fire) begin
        zero          <= (src_a == src_b);
        signed_less   <= $signed(src_a) < $signed(src_b);
        unsigned_less <= src_a < src_b;
        if (!multi) result <= quick;
      end else if (state_q == S_CALC && md_done) begin
        result <= md_result;
      end
    end
  end

  iter_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (fire && multi),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .done   (md_done),
    .result (md_result)
  );

endmodule
